// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field layout, architectural sizes and
// opcode values that must match the Execution stage.
package cpu_pkg;

  localparam int unsigned NREGS = 32;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned ILEN  = 32;

  // Instruction field bit positions
  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 25;
  localparam int unsigned DST_MSB = 24;
  localparam int unsigned DST_LSB = 20;
  localparam int unsigned RS1_MSB = 19;
  localparam int unsigned RS1_LSB = 15;
  localparam int unsigned RS2_MSB = 14;
  localparam int unsigned RS2_LSB = 10;
  localparam int unsigned OFF_MSB = 9;
  localparam int unsigned OFF_LSB = 0;

  // Opcode values shared with Execution
  typedef enum logic [6:0] {
    OP_ADD = 7'h00,
    OP_SUB = 7'h01
  } opcode_e;

  // Decoded view of one instruction word
  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] dst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [9:0] offsetlo;
  } instr_fields_t;

  // Split an instruction word into its fields
  function automatic instr_fields_t decode_fields(input logic [ILEN-1:0] w);
    instr_fields_t f;
    f.opcode   = w[OPC_MSB:OPC_LSB];
    f.dst      = w[DST_MSB:DST_LSB];
    f.rs1      = w[RS1_MSB:RS1_LSB];
    f.rs2      = w[RS2_MSB:RS2_LSB];
    f.offsetlo = w[OFF_MSB:OFF_LSB];
    return f;
  endfunction

endpackage

// File: rtl/regfile.sv
// Register file: two combinational read ports, one synchronous write port.
// r0 always reads zero and ignores writes. Contents are not reset.
// Optional DECODE_WB_BYPASS_EN: a read of the register being written this
// cycle returns the write data instead of the stored value.
module regfile
  import cpu_pkg::*;
#(
  parameter int unsigned NREGS = cpu_pkg::NREGS,
  parameter int unsigned XLEN  = cpu_pkg::XLEN
) (
  input  logic            clk,
  input  logic [4:0]      raddr1_i,
  input  logic [4:0]      raddr2_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o,
  input  logic            we_i,
  input  logic [4:0]      waddr_i,
  input  logic [XLEN-1:0] wdata_i
);

  logic [XLEN-1:0] mem_q [NREGS];

  // Write port; index 0 is never stored
  always_ff @(posedge clk) begin
    if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port 1
  always_comb begin
    rdata1_o = mem_q[raddr1_i];
`ifdef DECODE_WB_BYPASS_EN
    if (we_i && (waddr_i == raddr1_i)) rdata1_o = wdata_i;
`endif
    if (raddr1_i == '0) rdata1_o = '0;
  end

  // Read port 2
  always_comb begin
    rdata2_o = mem_q[raddr2_i];
`ifdef DECODE_WB_BYPASS_EN
    if (we_i && (waddr_i == raddr2_i)) rdata2_o = wdata_i;
`endif
    if (raddr2_i == '0) rdata2_o = '0;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: single-entry holding register fed by fetch over valid/ready,
// scoreboard of pending writes, register-file read and a registered operand
// bundle for Execution.
// Optional DECODE_WB_BYPASS_EN: a source being written back this cycle is not
// a hazard and its value is forwarded, so the dependent issues one cycle earlier.
module decode_stage
  import cpu_pkg::*;
#(
  parameter int unsigned NREGS = cpu_pkg::NREGS,
  parameter int unsigned XLEN  = cpu_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  output logic            instr_ready,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_dst,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  output logic [6:0]      opcode,
  output logic [4:0]      dstout,
  output logic [XLEN-1:0] src1,
  output logic [XLEN-1:0] src2,
  output logic [9:0]      offsetlo,
  output logic            stall
);

  instr_fields_t   hold_q, hold_d;
  logic            hold_valid_q, hold_valid_d;
  logic [NREGS-1:0] pend_q, pend_d;
  logic [NREGS-1:0] wb_clr;
  logic [NREGS-1:0] pend_chk;
  logic            hazard, issue, accept;
  logic [XLEN-1:0] rd1, rd2;

  logic            ex_valid_q;
  logic [6:0]      opcode_q;
  logic [4:0]      dst_q;
  logic [XLEN-1:0] src1_q, src2_q;
  logic [9:0]      off_q;

  regfile #(
    .NREGS(NREGS),
    .XLEN (XLEN)
  ) u_regfile (
    .clk     (clk),
    .raddr1_i(hold_q.rs1),
    .raddr2_i(hold_q.rs2),
    .rdata1_o(rd1),
    .rdata2_o(rd2),
    .we_i    (wb_en),
    .waddr_i (wb_dst),
    .wdata_i (wb_data)
  );

  // One-hot of the register retiring this cycle
  always_comb begin
    wb_clr = '0;
    if (wb_en) wb_clr[wb_dst] = 1'b1;
  end

  // Hazard detection and handshake
  always_comb begin
`ifdef DECODE_WB_BYPASS_EN
    pend_chk = pend_q & ~wb_clr;
`else
    pend_chk = pend_q;
`endif
    hazard      = hold_valid_q & (pend_chk[hold_q.rs1] | pend_chk[hold_q.rs2]);
    issue       = hold_valid_q & ~hazard & ~flush;
    instr_ready = (~hold_valid_q | issue) & ~flush;
    accept      = instr_valid & instr_ready;
  end

  // Next state of the holding register
  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    if (accept) begin
      hold_d       = decode_fields(instr);
      hold_valid_d = 1'b1;
    end else if (issue || flush) begin
      hold_valid_d = 1'b0;
    end
  end

  // Scoreboard next state: clear on writeback, then set on issue so the set wins
  always_comb begin
    pend_d = pend_q & ~wb_clr;
    if (issue && (hold_q.dst != '0)) pend_d[hold_q.dst] = 1'b1;
    pend_d[0] = 1'b0;
  end

  // Holding register and scoreboard state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      pend_q       <= '0;
    end else begin
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      pend_q       <= pend_d;
    end
  end

  // Output bundle to Execution, loaded on issue; valid lasts one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      opcode_q   <= '0;
      dst_q      <= '0;
      src1_q     <= '0;
      src2_q     <= '0;
      off_q      <= '0;
    end else begin
      ex_valid_q <= issue;
      if (issue) begin
        opcode_q <= hold_q.opcode;
        dst_q    <= hold_q.dst;
        src1_q   <= rd1;
        src2_q   <= rd2;
        off_q    <= hold_q.offsetlo;
      end
    end
  end

  assign ex_valid = ex_valid_q;
  assign opcode   = opcode_q;
  assign dstout   = dst_q;
  assign src1     = src1_q;
  assign src2     = src2_q;
  assign offsetlo = off_q;
  assign stall    = hazard;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage; expectations follow the
// DECODE_WB_BYPASS_EN setting of the build.
module tb_decode_stage;
  import cpu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_dst;
  logic [31:0] wb_data;
  logic        ex_valid;
  logic [6:0]  opcode;
  logic [4:0]  dstout;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [9:0]  offsetlo;
  logic        stall;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  decode_stage #(
    .NREGS(32),
    .XLEN (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_ready(instr_ready),
    .flush      (flush),
    .wb_en      (wb_en),
    .wb_dst     (wb_dst),
    .wb_data    (wb_data),
    .ex_valid   (ex_valid),
    .opcode     (opcode),
    .dstout     (dstout),
    .src1       (src1),
    .src2       (src2),
    .offsetlo   (offsetlo),
    .stall      (stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] d,
                                     input logic [4:0] r1, input logic [4:0] r2,
                                     input logic [9:0] off);
    return {op, d, r1, r2, off};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] d, input logic [31:0] v);
    wb_en   = 1'b1;
    wb_dst  = d;
    wb_data = v;
    tick();
    wb_en   = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1; instr_valid = 1'b0; instr = '0; flush = 1'b0;
    wb_en = 1'b0; wb_dst = '0; wb_data = '0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_ex_valid", 32'(ex_valid), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_opcode", 32'(opcode), 32'd0);
    check("rst_src1", src1, 32'd0);
    #9 rst_n = 1'b1;
    tick();
    check("rst_ready", 32'(instr_ready), 32'd1);

    // Preload, plus a write to r0 that must be ignored
    wb_write(5'd5, 32'd20);
    wb_write(5'd6, 32'd10);
    wb_write(5'd0, 32'hDEADBEEF);

    // Basic ADD r3 = r5, r6
    instr_valid = 1'b1; instr = mk(OP_ADD, 5'd3, 5'd5, 5'd6, 10'd0);
    tick();
    instr_valid = 1'b0;
    #1 check("add_no_stall", 32'(stall), 32'd0);
    tick();
    check("add_ex_valid", 32'(ex_valid), 32'd1);
    check("add_opcode", 32'(opcode), 32'h00);
    check("add_dst", 32'(dstout), 32'd3);
    check("add_src1", src1, 32'd20);
    check("add_src2", src2, 32'd10);
    tick();
    check("add_valid_drop", 32'(ex_valid), 32'd0);

    // SUB r8 then dependent ADD r9 = r8 + r0
    instr_valid = 1'b1; instr = mk(OP_SUB, 5'd8, 5'd5, 5'd6, 10'd0);
    tick();
    instr = mk(OP_ADD, 5'd9, 5'd8, 5'd0, 10'd0);
    #1 check("b2b_ready", 32'(instr_ready), 32'd1);
    tick();
    check("sub_ex_valid", 32'(ex_valid), 32'd1);
    check("sub_opcode", 32'(opcode), 32'h01);
    check("sub_dst", 32'(dstout), 32'd8);
    #1;
    check("dep_stall", 32'(stall), 32'd1);
    check("dep_ready", 32'(instr_ready), 32'd0);
    instr_valid = 1'b0;
    tick();
    check("dep_no_issue", 32'(ex_valid), 32'd0);
    wb_en = 1'b1; wb_dst = 5'd8; wb_data = 32'd30;
    #1;
`ifdef DECODE_WB_BYPASS_EN
    check("dep_wb_stall", 32'(stall), 32'd0);
    tick();
    wb_en = 1'b0;
`else
    check("dep_wb_stall", 32'(stall), 32'd1);
    tick();
    wb_en = 1'b0;
    check("dep_wb_no_issue", 32'(ex_valid), 32'd0);
    #1 check("dep_post_wb_stall", 32'(stall), 32'd0);
    tick();
`endif
    check("dep_ex_valid", 32'(ex_valid), 32'd1);
    check("dep_dst", 32'(dstout), 32'd9);
    check("dep_src1", src1, 32'd30);
    tick();
    check("dep_valid_drop", 32'(ex_valid), 32'd0);

    // r0 handling: dst 0 sets nothing, reads of r0 give 0
    instr_valid = 1'b1; instr = mk(OP_ADD, 5'd0, 5'd0, 5'd5, 10'd0);
    tick();
    instr = mk(OP_SUB, 5'd0, 5'd0, 5'd0, 10'd0);
    tick();
    instr_valid = 1'b0;
    check("r0_ex_valid", 32'(ex_valid), 32'd1);
    check("r0_src1", src1, 32'd0);
    check("r0_src2", src2, 32'd20);
    #1 check("r0_no_stall", 32'(stall), 32'd0);
    tick();
    check("r0_next_valid", 32'(ex_valid), 32'd1);
    check("r0_next_src1", src1, 32'd0);
    check("r0_next_src2", src2, 32'd0);
    tick();

    // Flush while stalled on r10
    instr_valid = 1'b1; instr = mk(OP_SUB, 5'd10, 5'd5, 5'd6, 10'd0);
    tick();
    instr = mk(OP_ADD, 5'd11, 5'd10, 5'd0, 10'd0);
    tick();
    instr_valid = 1'b0;
    #1 check("fl_stall", 32'(stall), 32'd1);
    flush = 1'b1; instr_valid = 1'b1; instr = mk(OP_ADD, 5'd14, 5'd5, 5'd5, 10'd0);
    #1 check("fl_ready", 32'(instr_ready), 32'd0);
    tick();
    flush = 1'b0; instr_valid = 1'b0;
    #1;
    check("fl_ex_valid", 32'(ex_valid), 32'd0);
    check("fl_hold_clear", 32'(stall), 32'd0);
    check("fl_ready_after", 32'(instr_ready), 32'd1);
    instr_valid = 1'b1; instr = mk(OP_ADD, 5'd15, 5'd10, 5'd6, 10'd0);
    tick();
    instr_valid = 1'b0;
    #1 check("fl_pend_kept", 32'(stall), 32'd1);
    wb_en = 1'b1; wb_dst = 5'd10; wb_data = 32'd55;
    tick();
    wb_en = 1'b0;
`ifdef DECODE_WB_BYPASS_EN
    check("fl_wb_valid", 32'(ex_valid), 32'd1);
`else
    check("fl_wb_valid", 32'(ex_valid), 32'd0);
    tick();
    check("fl_late_valid", 32'(ex_valid), 32'd1);
`endif
    check("fl_src1", src1, 32'd55);
    check("fl_src2", src2, 32'd10);
    tick();

    // Asynchronous reset in the middle of a stall
    instr_valid = 1'b1; instr = mk(OP_SUB, 5'd8, 5'd5, 5'd6, 10'h155);
    tick();
    instr = mk(OP_ADD, 5'd13, 5'd8, 5'd0, 10'd0);
    tick();
    instr_valid = 1'b0;
    #1;
    check("pre_rst_valid", 32'(ex_valid), 32'd1);
    check("pre_rst_stall", 32'(stall), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_ex_valid", 32'(ex_valid), 32'd0);
    check("mid_rst_opcode", 32'(opcode), 32'd0);
    check("mid_rst_dst", 32'(dstout), 32'd0);
    check("mid_rst_src1", src1, 32'd0);
    check("mid_rst_src2", src2, 32'd0);
    check("mid_rst_off", 32'(offsetlo), 32'd0);
    check("mid_rst_stall", 32'(stall), 32'd0);
    #3 rst_n = 1'b1;
    tick();
    check("post_rst_ready", 32'(instr_ready), 32'd1);
    instr_valid = 1'b1; instr = mk(OP_ADD, 5'd13, 5'd8, 5'd5, 10'd3);
    tick();
    instr_valid = 1'b0;
    #1 check("post_rst_no_stall", 32'(stall), 32'd0);
    tick();
    check("post_rst_valid", 32'(ex_valid), 32'd1);
    check("post_rst_src1", src1, 32'd30);
    check("post_rst_src2", src2, 32'd20);
    check("post_rst_off", 32'(offsetlo), 32'd3);
    tick();

    // Stream of 8 independent instructions
    instr_valid = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) instr = mk(7'(i), 5'(16 + i), 5'd0, 5'd5, 10'(i * 7 + 1));
      else instr_valid = 1'b0;
      #1;
      if (i < 8) check("str_ready", 32'(instr_ready), 32'd1);
      check("str_stall", 32'(stall), 32'd0);
      tick();
      if (i > 0) begin
        check("str_valid", 32'(ex_valid), 32'd1);
        check("str_opcode", 32'(opcode), 32'(i - 1));
        check("str_dst", 32'(dstout), 32'(16 + i - 1));
        check("str_off", 32'(offsetlo), 32'((i - 1) * 7 + 1));
        check("str_src2", src2, 32'd20);
      end
    end
    tick();
    check("str_end_valid", 32'(ex_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Decode stage of the five-stage pipeline, between fetch and `Execution`. Accepts 32-bit instructions from fetch over a valid/ready handshake and splits them into fields. Reads operands from an internal 32×32 register file written by the writeback stage. Holds any instruction whose sources have pending writes (scoreboard stall), and presents a registered operand bundle to `Execution` in exactly the form that stage consumes.

## Interface
- `NREGS`, 32: number of architectural registers; `r0` reads zero.
- `XLEN`, 32: operand/result width.
- `clk`  in  1  pipeline clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `instr_valid`  in  1  fetch has an instruction.
- `instr`  in  32  instruction word.
- `instr_ready`  out  1  decode accepts `instr` this cycle.
- `flush`  in  1  drop the held instruction and the output bundle.
- `wb_en`  in  1  writeback write strobe.
- `wb_dst`  in  5  writeback register index.
- `wb_data`  in  XLEN  writeback data.
- `ex_valid`  out  1  bundle valid for `Execution`.
- `opcode`  out  7  to `Execution`.
- `dstout`  out  5  to `Execution` (`dstin` there).
- `src1`, `src2`  out  XLEN  operand values.
- `offsetlo`  out  10  immediate.
- `stall`  out  1  hazard stall this cycle (debug/perf).

## Operation
- Instruction fields:
  - `opcode` = `instr[31:25]`
  - `dst` = `instr[24:20]`
  - `rs1` = `instr[19:15]`
  - `rs2` = `instr[14:10]`
  - `offsetlo` = `instr[9:0]`
- Single holding register `hold` plus a valid bit.
  - `instr_ready` = `!hold_valid | issue`.
  - A fetch transfer occurs when `instr_valid & instr_ready`.
- Scoreboard: `NREGS`-bit pending vector.
  - Set bit `dst` on issue when `dst != 0`.
  - Clear bit `wb_dst` when `wb_en`.
  - On a same-register set and clear in one cycle, the set wins.
  - Bit 0 is never set.
- Hazard: `hold_valid` and the pending bit of `rs1` or `rs2` is set, with the exception given under Configuration. `stall` = hazard.
- Issue: `hold_valid & !hazard & !flush`. Issue registers the bundle into the output flops and sets `ex_valid`.
  - `ex_valid` clears on any cycle without an issue.
  - `Execution` never back-pressures, so every bundle is consumed in one cycle.
- Register file:
  - Written on `wb_en` when `wb_dst != 0`.
  - Reads of index 0 return 0.
  - Writes to 0 are ignored.
- `flush`:
  - Clears `hold_valid` and `ex_valid`.
  - Forces `instr_ready` = 0 that cycle, so no fetch transfer occurs.
  - Scoreboard untouched, because writes already issued still retire.
- Arithmetic: none; purely field extraction and selection. Widths pass through unchanged.

## Timing
- Reset (async, `rst_n` low): outputs and state go to these values immediately.
  - `ex_valid`=0, `stall`=0.
  - `opcode`, `dstout`, `src1`, `src2`, `offsetlo` = 0.
  - `hold_valid`=0, scoreboard all 0.
  - `instr_ready`=1 after reset deassertion.
  - Register file contents are not reset.
- Latency: an instruction accepted at edge N issues at edge N+1 if it has no hazard; `ex_valid` is high in the cycle after that edge.
- Throughput: one instruction per cycle with no hazards.
- Stall: the hold register keeps its contents and `instr_ready`=0 until the pending bit clears.
- Back-to-back accept and issue in the same cycle is legal.
- Reset mid-stall drops the held instruction.

## Configuration
- `DECODE_WB_BYPASS_EN` defined:
  - A read whose index equals `wb_dst` with `wb_en` (and index ≠ 0) returns `wb_data`.
  - The hazard check ignores a pending bit that is being cleared this cycle.
  - The dependent instruction issues in the writeback cycle.
- Undefined:
  - No bypass; the register file returns the pre-write value.
  - The hazard persists until the cycle after the write, giving one extra stall cycle.

## Structure
- Shared package `cpu_pkg`:
  - Field bit positions, `NREGS`, `XLEN`.
  - Opcode constants, e.g. `OP_ADD`=7'h00, `OP_SUB`=7'h01, matching `Execution`.
- Sub-module `regfile`: 2 read ports, 1 write port, `r0` zero, with the optional bypass inside.
- Scoreboard and handshake logic stay in `decode_stage`.

## Test plan
- Reset with `r5`=20 and `r6`=10 preloaded via wb; ADD `dst`=3, `rs1`=5, `rs2`=6, `offsetlo`=0 → one cycle later `ex_valid`=1, `opcode`=0x00, `dstout`=3, `src1`=20, `src2`=10.
- SUB to `r8` then ADD reading `r8`; wb of `r8`=30 two cycles later → second instruction stalls, `instr_ready`=0, then issues with `src1`=30. Issue occurs in the wb cycle with the bypass, one cycle later without it.
- Instruction with `rs1`=0 and `dst`=0 → `src1`=0 and no scoreboard bit set; the next instruction reading `r0` does not stall.
- `flush` asserted while an instruction is held in a stall → `ex_valid` stays 0, `hold_valid` clears, the later wb still clears the pending bit.
- `rst_n` pulled low mid-stall, asynchronously between edges → all outputs 0 immediately, the scoreboard cleared, and `instr_ready`=1 after release.
- Stream of 8 independent instructions with `instr_valid` held high → 8 consecutive `ex_valid` cycles with no stall.
